// File: rtl/xtea_dec_sched.sv
// Round-robin scheduler that shares one xtea_dec core between two request/response channels.
// Define XTEA_SCHED_TIMEOUT_EN to add a watchdog that aborts a job whose core never answers.
module xtea_dec_sched #(
  parameter int WORD_SIZE = 128,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WORD_SIZE-1:0] req0_data,
  input  logic [WORD_SIZE-1:0] req0_key,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WORD_SIZE-1:0] req1_data,
  input  logic [WORD_SIZE-1:0] req1_key,
  output logic                 rsp0_valid,
  input  logic                 rsp0_ready,
  output logic                 rsp1_valid,
  input  logic                 rsp1_ready,
  output logic [WORD_SIZE-1:0] rsp_data,
  output logic                 rsp_err,
  output logic                 core_reset,
  output logic                 core_start,
  output logic [WORD_SIZE-1:0] core_data_in,
  output logic [WORD_SIZE-1:0] core_key,
  input  logic                 core_ready,
  input  logic [WORD_SIZE-1:0] core_data_out,
  output logic                 busy,
  output logic                 grant_id
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("xtea_dec_sched: TIMEOUT must lie in 1..255");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic                   rr_q, rr_d;
  logic                   grant_q, grant_d;
  logic                   rsp0_valid_q, rsp0_valid_d;
  logic                   rsp1_valid_q, rsp1_valid_d;
  logic [WORD_SIZE-1:0]   rsp_data_q, rsp_data_d;
  logic [WORD_SIZE-1:0]   din_q, din_d;
  logic [WORD_SIZE-1:0]   key_q, key_d;
  logic                   winner;
  logic                   accept;
  logic                   rsp_taken;

`ifdef XTEA_SCHED_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
  logic [7:0] wd_cnt_q, wd_cnt_d;
  logic       rsp_err_q, rsp_err_d;
  logic       wd_fire;
`endif

  // A lone requester always wins; on contention the round-robin pointer decides.
  always_comb begin
    winner     = (req0_valid && req1_valid) ? rr_q : req1_valid;
    accept     = !reset && (state_q == S_IDLE) && (req0_valid || req1_valid);
    req0_ready = accept && !winner;
    req1_ready = accept && winner;
    rsp_taken  = grant_q ? rsp1_ready : rsp0_ready;
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d      = state_q;
    rr_d         = rr_q;
    grant_d      = grant_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp_data_d   = rsp_data_q;
    din_d        = din_q;
    key_d        = key_q;
`ifdef XTEA_SCHED_TIMEOUT_EN
    wd_cnt_d     = wd_cnt_q;
    rsp_err_d    = rsp_err_q;
    wd_fire      = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          din_d   = winner ? req1_data : req0_data;
          key_d   = winner ? req1_key  : req0_key;
          grant_d = winner;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
`ifdef XTEA_SCHED_TIMEOUT_EN
        wd_cnt_d = '0;
`endif
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (core_ready) begin
          rsp_data_d   = core_data_out;
          rsp0_valid_d = !grant_q;
          rsp1_valid_d = grant_q;
          state_d      = S_RESP;
`ifdef XTEA_SCHED_TIMEOUT_EN
          rsp_err_d    = 1'b0;
        end else if (wd_cnt_q == TIMEOUT_C) begin
          // The core is recovered by its own reset; the requester still gets an (error) answer.
          wd_fire      = 1'b1;
          rsp_data_d   = '0;
          rsp_err_d    = 1'b1;
          rsp0_valid_d = !grant_q;
          rsp1_valid_d = grant_q;
          state_d      = S_RESP;
        end else begin
          wd_cnt_d     = wd_cnt_q + 8'd1;
`endif
        end
      end

      S_RESP: begin
        if (rsp_taken) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          rr_d         = !grant_q;
          state_d      = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rr_q         <= 1'b0;
      grant_q      <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp_data_q   <= '0;
      din_q        <= '0;
      key_q        <= '0;
`ifdef XTEA_SCHED_TIMEOUT_EN
      wd_cnt_q     <= '0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
      state_q      <= state_d;
      rr_q         <= rr_d;
      grant_q      <= grant_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp_data_q   <= rsp_data_d;
      din_q        <= din_d;
      key_q        <= key_d;
`ifdef XTEA_SCHED_TIMEOUT_EN
      wd_cnt_q     <= wd_cnt_d;
      rsp_err_q    <= rsp_err_d;
`endif
    end
  end

  assign rsp0_valid   = rsp0_valid_q;
  assign rsp1_valid   = rsp1_valid_q;
  assign rsp_data     = rsp_data_q;
  assign core_start   = (state_q == S_ISSUE);
  assign core_data_in = din_q;
  assign core_key     = key_q;
  assign busy         = (state_q != S_IDLE);
  assign grant_id     = grant_q;

`ifdef XTEA_SCHED_TIMEOUT_EN
  assign rsp_err    = rsp_err_q;
  assign core_reset = reset || wd_fire;
`else
  assign rsp_err    = 1'b0;
  assign core_reset = reset;
`endif

endmodule

// File: tb/tb_xtea_dec_sched.sv
// Self-checking bench for xtea_dec_sched: behavioural XTEA core stand-in plus a job-level scoreboard.
// Directed cases from the test plan, then randomized traffic; watchdog case only with XTEA_SCHED_TIMEOUT_EN.
module tb_xtea_dec_sched;

  localparam int W  = 128;
  localparam int TO = 20;
`ifdef XTEA_SCHED_TIMEOUT_EN
  localparam int LAT_LONG = 15;
  localparam int RST_DLY  = 8;
`else
  localparam int LAT_LONG = 97;
  localparam int RST_DLY  = 40;
`endif

  localparam logic [W-1:0] KV_CT  = 128'h497df3d0_72612cb5_497df3d0_72612cb5;
  localparam logic [W-1:0] KV_KEY = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [W-1:0] KV_PT  = 128'h41424344_45464748_41424344_45464748;
  localparam logic [W-1:0] ZV_CT  = 128'hdee9d4d8_f7131ed9_dee9d4d8_f7131ed9;

  logic         clock, reset;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_data, req0_key, req1_data, req1_key;
  logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_err, core_reset, core_start, core_ready, busy, grant_id;
  logic [W-1:0] core_data_in, core_key, core_data_out;

  xtea_dec_sched #(.WORD_SIZE(W), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_key(req1_key),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .core_reset(core_reset), .core_start(core_start),
    .core_data_in(core_data_in), .core_key(core_key),
    .core_ready(core_ready), .core_data_out(core_data_out),
    .busy(busy), .grant_id(grant_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference XTEA decipher of one 64-bit block, 32 cycles, k0 in key[127:96].
  function automatic logic [63:0] xtea_blk(input logic [63:0] v, input logic [W-1:0] k);
    logic [31:0] v0, v1, sum;
    logic [31:0] kw [4];
    kw[0] = k[127:96]; kw[1] = k[95:64]; kw[2] = k[63:32]; kw[3] = k[31:0];
    v0  = v[63:32];
    v1  = v[31:0];
    sum = 32'hC6EF3720;
    for (int i = 0; i < 32; i++) begin
      v1  = v1 - ((((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + kw[sum[12:11]]));
      sum = sum - 32'h9E3779B9;
      v0  = v0 - ((((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + kw[sum[1:0]]));
    end
    return {v0, v1};
  endfunction

  function automatic logic [W-1:0] xtea_dec(input logic [W-1:0] d, input logic [W-1:0] k);
    return {xtea_blk(d[127:64], k), xtea_blk(d[63:0], k)};
  endfunction

  function automatic logic [W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Core stand-in: answers core_start after a programmable delay, optionally hangs or
  // emits stray core_ready pulses while it has no job.
  bit           cm_busy, core_hang, stray_en, rand_lat;
  int           cm_cnt, core_lat;
  logic [W-1:0] cm_result;

  initial begin
    core_ready = 1'b0; core_data_out = '0; cm_busy = 0; cm_cnt = 0; cm_result = '0;
    forever begin
      @(posedge clock); #1;
      core_ready = 1'b0;
      if (core_reset) cm_busy = 0;
      else if (cm_busy) begin
        if (!core_hang) begin
          if (cm_cnt == 0) begin
            core_ready = 1'b1; core_data_out = cm_result; cm_busy = 0;
          end else cm_cnt--;
        end
      end else if (core_start) begin
        cm_busy   = 1;
        cm_cnt    = rand_lat ? int'($urandom_range(0, 12)) : core_lat;
        cm_result = xtea_dec(core_data_in, core_key);
      end else if (stray_en && $urandom_range(0, 7) == 0) begin
        core_ready = 1'b1; core_data_out = rnd128();
      end
    end
  end

  // Job-level scoreboard: phase 0 = no job, 1 = job handed to core, 2 = answer pending.
  bit           mon_en, m_rr, m_owner, m_start_due;
  int           m_phase, m_last_acc, n_done;
  logic [W-1:0] m_din, m_key, m_exp, m_rsp;
  int           grant_log [$];

  task automatic observe();
    bit w, acc, er0, er1, issue;
    #1;
    m_last_acc = -1;
    if (!mon_en) return;
    w   = (req0_valid && req1_valid) ? m_rr : req1_valid;
    acc = !reset && (m_phase == 0) && (req0_valid || req1_valid);
    er0 = acc && !w;
    er1 = acc && w;
    check("req0_ready",   128'(req0_ready), 128'(er0));
    check("req1_ready",   128'(req1_ready), 128'(er1));
    check("busy",         128'(busy), 128'(m_phase != 0));
    check("core_start",   128'(core_start), 128'(m_start_due));
    check("core_reset",   128'(core_reset), 128'(reset));
    check("grant_id",     128'(grant_id), 128'(m_owner));
    check("core_data_in", core_data_in, m_din);
    check("core_key",     core_key, m_key);
    check("rsp0_valid",   128'(rsp0_valid), 128'(m_phase == 2 && !m_owner));
    check("rsp1_valid",   128'(rsp1_valid), 128'(m_phase == 2 && m_owner));
    check("rsp_data",     rsp_data, m_rsp);
    check("rsp_err",      128'(rsp_err), 128'(0));
    issue       = m_start_due;
    m_start_due = 0;
    if (reset) begin
      m_phase = 0; m_rr = 0; m_owner = 0; m_din = '0; m_key = '0; m_rsp = '0;
    end else begin
      case (m_phase)
        0: if (acc) begin
          m_owner     = w;
          m_din       = w ? req1_data : req0_data;
          m_key       = w ? req1_key : req0_key;
          m_exp       = xtea_dec(m_din, m_key);
          m_phase     = 1;
          m_start_due = 1;
          m_last_acc  = int'(w);
          grant_log.push_back(int'(w));
        end
        1: if (core_ready && !issue) begin
          m_rsp   = m_exp;
          m_phase = 2;
        end
        default: if (m_owner ? rsp1_ready : rsp0_ready) begin
          m_phase = 0;
          m_rr    = !m_owner;
          n_done++;
        end
      endcase
    end
  endtask

  task automatic tick();
    observe();
    @(posedge clock); #2;
  endtask

  task automatic wait_phase(input int p, input int bound, input string tag, output int n);
    n = 0;
    while (m_phase != p && n < bound) begin
      tick();
      n++;
    end
    check({tag, "_reached"}, 128'(m_phase == p), 128'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "tb_xtea_dec_sched: time limit");
  end

  initial begin
    int           n, saved;
    logic [W-1:0] held;
    reset = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_data = '0; req0_key = '0; req1_data = '0; req1_key = '0;
    mon_en = 0; stray_en = 0; core_hang = 0; rand_lat = 0; core_lat = LAT_LONG;
    m_rr = 0; m_owner = 0; m_start_due = 0; m_phase = 0; m_last_acc = -1; n_done = 0;
    m_din = '0; m_key = '0; m_exp = '0; m_rsp = '0;

    // Reset values, with both requesters asserting valid.
    @(posedge clock); #2;
    req0_valid = 1; req1_valid = 1;
    #1;
    check("rst_req0_ready", 128'(req0_ready), 128'(0));
    check("rst_req1_ready", 128'(req1_ready), 128'(0));
    check("rst_core_reset", 128'(core_reset), 128'(1));
    check("rst_busy",       128'(busy), 128'(0));
    check("rst_core_start", 128'(core_start), 128'(0));
    check("rst_rsp_valids", 128'({rsp0_valid, rsp1_valid}), 128'(0));
    check("rst_rsp_data",   rsp_data, 128'(0));
    check("rst_core_data",  core_data_in, 128'(0));
    check("rst_core_key",   core_key, 128'(0));
    check("rst_grant_id",   128'(grant_id), 128'(0));
    mon_en = 1;
    tick();
    req0_valid = 0; req1_valid = 0;
    tick();
    reset = 1'b0;
    tick();

    // Known vector on requester 0; response lands lat+2 cycles after core_start.
    req0_data = KV_CT; req0_key = KV_KEY; req0_valid = 1;
    wait_phase(1, 10, "kv_accept", n);
    req0_valid = 0;
    wait_phase(2, 400, "kv_rsp", n);
    check("kv_latency",   128'(n), 128'(LAT_LONG + 2));
    check("kv_rsp_data",  rsp_data, KV_PT);
    check("kv_rsp0",      128'({rsp0_valid, rsp1_valid}), 128'(2'b10));
    rsp0_ready = 1;
    wait_phase(0, 5, "kv_done", n);
    rsp0_ready = 0;

    // Zero-plaintext vector on requester 1, rsp_ready held high in advance.
    req1_data = ZV_CT; req1_key = '0; req1_valid = 1; rsp1_ready = 1;
    wait_phase(1, 10, "zv_accept", n);
    req1_valid = 0;
    wait_phase(2, 400, "zv_rsp", n);
    check("zv_rsp_data", rsp_data, 128'(0));
    wait_phase(0, 5, "zv_done", n);
    check("zv_handshake_first_cycle", 128'(n), 128'(1));
    rsp1_ready = 0;

    // Contention: both valid continuously, responses consumed at once.
    grant_log.delete();
    saved = n_done; core_lat = 3; rsp0_ready = 1; rsp1_ready = 1;
    req0_data = rnd128(); req0_key = rnd128(); req1_data = rnd128(); req1_key = rnd128();
    req0_valid = 1; req1_valid = 1;
    n = 0;
    while (n_done < saved + 4 && n < 300) begin
      tick();
      n++;
    end
    req0_valid = 0; req1_valid = 0;
    check("cont_jobs", 128'(n_done - saved), 128'(4));
    for (int i = 0; i < 4; i++) check("cont_grant_order", 128'(grant_log[i]), 128'(i % 2));
    rsp0_ready = 0; rsp1_ready = 0;

    // Backpressure on channel 0 while requester 1 waits.
    core_lat = 5;
    req0_data = rnd128(); req0_key = rnd128(); req0_valid = 1;
    wait_phase(1, 10, "bp_accept0", n);
    req0_valid = 0;
    req1_data = rnd128(); req1_key = rnd128(); req1_valid = 1;
    wait_phase(2, 100, "bp_rsp0", n);
    held = rsp_data;
    repeat (50) tick();
    check("bp_data_stable", rsp_data, held);
    check("bp_rsp0_held",   128'(rsp0_valid), 128'(1));
    rsp0_ready = 1;
    tick();
    rsp0_ready = 0;
    #1;
    check("bp_next_accept", 128'(req1_ready), 128'(1));
    wait_phase(1, 3, "bp_accept1", n);
    req1_valid = 0; rsp1_ready = 1;
    wait_phase(0, 100, "bp_done1", n);
    rsp1_ready = 0;

    // Reset in the middle of WAIT drops the job.
    core_lat = LAT_LONG; saved = n_done;
    req0_data = rnd128(); req0_key = rnd128(); req0_valid = 1;
    wait_phase(1, 10, "rmw_accept", n);
    req0_valid = 0;
    repeat (RST_DLY) tick();
    check("rmw_busy_before", 128'(busy), 128'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rmw_busy_after", 128'(busy), 128'(0));
    check("rmw_core_data",  core_data_in, 128'(0));
    check("rmw_rsp_data",   rsp_data, 128'(0));
    repeat (LAT_LONG + 20) tick();
    check("rmw_no_rsp", 128'(n_done), 128'(saved));
    req1_data = rnd128(); req1_key = rnd128(); req1_valid = 1; rsp1_ready = 1;
    wait_phase(1, 10, "rmw_new_accept", n);
    req1_valid = 0;
    wait_phase(0, 400, "rmw_new_done", n);
    check("rmw_new_job", 128'(n_done), 128'(saved + 1));
    rsp1_ready = 0;

    // Randomized traffic with stray core_ready pulses and withdrawn requests.
    saved = n_done; stray_en = 1; rand_lat = 1;
    for (int c = 0; c < 1500; c++) begin
      if (!req0_valid) begin
        if ($urandom_range(0, 2) == 0) begin req0_valid = 1; req0_data = rnd128(); req0_key = rnd128(); end
      end else if ($urandom_range(0, 9) == 0) req0_valid = 0;
      if (!req1_valid) begin
        if ($urandom_range(0, 2) == 0) begin req1_valid = 1; req1_data = rnd128(); req1_key = rnd128(); end
      end else if ($urandom_range(0, 9) == 0) req1_valid = 0;
      rsp0_ready = 1'($urandom_range(0, 1));
      rsp1_ready = 1'($urandom_range(0, 1));
      tick();
      if (m_last_acc == 0) req0_valid = 0;
      if (m_last_acc == 1) req1_valid = 0;
    end
    req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1; stray_en = 0;
    wait_phase(0, 100, "rand_drain", n);
    check("rand_progress", 128'(n_done - saved > 20), 128'(1));
    rsp0_ready = 0; rsp1_ready = 0; rand_lat = 0;

`ifdef XTEA_SCHED_TIMEOUT_EN
    // Watchdog: the core never answers.
    core_hang = 1;
    req0_data = rnd128(); req0_key = rnd128(); req0_valid = 1;
    wait_phase(1, 10, "wd_accept", n);
    req0_valid = 0;
    mon_en = 0;
    tick();
    n = 0;
    while (!core_reset && n < 100) begin
      tick();
      n++;
    end
    check("wd_wait_cycles", 128'(n), 128'(TO));
    tick();
    check("wd_pulse_width", 128'(core_reset), 128'(0));
    check("wd_rsp0_valid",  128'({rsp0_valid, rsp1_valid}), 128'(2'b10));
    check("wd_rsp_err",     128'(rsp_err), 128'(1));
    check("wd_rsp_data",    rsp_data, 128'(0));
    rsp0_ready = 1;
    tick();
    rsp0_ready = 0;
    check("wd_idle", 128'(busy), 128'(0));
    core_hang = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
